round_sequencer: RTL and testbench

Game-round controller in the clk60MHz domain; it sequences each turn of the two-board throwing game. It waits for both players to be ready, then runs the turn: power charge from the mouse button, projectile flight, hit scoring and the hand-over to the other player. It also detects game over. It sits between choose_player/MouseCtl (inputs) and the throw and draw logic (outputs), and it replaces ad-hoc turn bookkeeping with one FSM.

---
 rtl/round_seq_pkg.sv | 18 +
 rtl/round_sequencer_power_charger.sv | 73 +++++++
 rtl/round_sequencer.sv | 158 +++++++++++++++
 tb/tb_round_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_seq_pkg.sv
// Shared types and widths for the game-round sequencer.
package round_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AIM    = 3'd1,
    ST_REMOTE = 3'd2,
    ST_FLIGHT = 3'd3,
    ST_SCORE  = 3'd4,
    ST_SWITCH = 3'd5,
    ST_OVER   = 3'd6
  } state_t;

  localparam int HP_W  = 2;
  localparam int PWR_W = 5;
  localparam logic [PWR_W-1:0] POWER_MAX = 5'd31;

endpackage

// File: rtl/round_sequencer_power_charger.sv
// Mouse-driven launch power: 2-FF sync of the button, arm flag, prescaled
// saturating power count, and a release strobe that requests a launch.
module power_charger
  import round_seq_pkg::*;
#(
  parameter int CHARGE_DIV = 1_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [PWR_W-1:0] i_load_val,
  input  logic             i_left,
  output logic [PWR_W-1:0] o_power,
  output logic             o_release
);

  localparam int PW = $clog2(CHARGE_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CHARGE_DIV - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_left_d;
  logic             r_arm;
  logic [PW-1:0]    r_presc;
  logic [PWR_W-1:0] r_power;
  logic             w_fall;
  logic             w_charging;
  logic             w_tick;

  assign w_fall     = r_left_d & ~r_sync2;
  assign w_charging = i_en & r_arm & r_sync2;
  assign w_tick     = w_charging && (r_presc == PRESC_LAST);
  // A release with nothing charged keeps the turn open instead of launching.
  assign o_release  = i_en & r_arm & w_fall & (r_power != '0);
  assign o_power    = r_power;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_left_d <= 1'b0;
      r_arm    <= 1'b0;
      r_presc  <= '0;
      r_power  <= '0;
    end else begin
      r_sync1  <= i_left;
      r_sync2  <= r_sync1;
      r_left_d <= r_sync2;

      // Arming requires seeing the button up, so a hold carried over from
      // the previous turn cannot start charging.
      if (!i_en)
        r_arm <= 1'b0;
      else if (!r_sync2)
        r_arm <= 1'b1;

      if (!w_charging || w_tick)
        r_presc <= '0;
      else
        r_presc <= r_presc + 1'b1;

      if (i_clear)
        r_power <= '0;
      else if (i_load)
        r_power <= i_load_val;
      else if (w_tick && (r_power != POWER_MAX))
        r_power <= r_power + 1'b1;
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Turn controller for the two-board throwing game: ready wait, aim/charge,
// remote launch, flight, scoring, hand-over and game-over detection.
// Optional flight timeout: define ROUND_SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for both players ready
// AIM    | local turn, charging power from the mouse
// REMOTE | opponent's turn, waiting for their launch
// FLIGHT | projectile in the air
// SCORE  | apply hit to the opponent's lives
// SWITCH | hand the turn to the other player
// OVER   | game finished, held until reset
module round_sequencer
  import round_seq_pkg::*;
#(
  parameter int CHARGE_DIV     = 1_000_000,
  parameter int FLIGHT_TIMEOUT = 180_000_000,
  parameter int HP_INIT        = 3
) (
  input  logic             clk60MHz,
  input  logic             rst,
  input  logic             both_ready,
  input  logic             local_player,
  input  logic             left,
  input  logic             remote_throw,
  input  logic [PWR_W-1:0] remote_power,
  input  logic             end_throw,
  input  logic             hit,
  output logic [PWR_W-1:0] power,
  output logic             throw_start,
  output logic             active_player,
  output logic [2:0]       turn,
  output logic [HP_W-1:0]  hp0,
  output logic [HP_W-1:0]  hp1,
  output logic             game_over,
  output logic             winner,
  output logic [2:0]       state
);

  state_t          r_state;
  logic            r_throw_start;
  logic            r_active;
  logic [2:0]      r_turn;
  logic [HP_W-1:0] r_hp0;
  logic [HP_W-1:0] r_hp1;
  logic            r_game_over;
  logic            r_winner;
  logic            r_hit_flag;
  logic            w_release;
  logic            w_timeout;
  logic [HP_W-1:0] w_opp_hp;
  logic [HP_W-1:0] w_opp_hp_nxt;

  power_charger #(
    .CHARGE_DIV (CHARGE_DIV)
  ) u_charger (
    .i_clk      (clk60MHz),
    .i_rst_n    (rst),
    .i_en       (r_state == ST_AIM),
    .i_clear    (r_state == ST_SWITCH),
    .i_load     ((r_state == ST_REMOTE) && remote_throw),
    .i_load_val (remote_power),
    .i_left     (left),
    .o_power    (power),
    .o_release  (w_release)
  );

`ifdef ROUND_SEQ_TIMEOUT_EN
  localparam int FCW = $clog2(FLIGHT_TIMEOUT + 1);
  logic [FCW-1:0] r_flight_cnt;

  always_ff @(posedge clk60MHz or negedge rst) begin
    if (!rst)
      r_flight_cnt <= '0;
    else if (r_state != ST_FLIGHT)
      r_flight_cnt <= '0;
    else
      r_flight_cnt <= r_flight_cnt + 1'b1;
  end

  assign w_timeout = (r_state == ST_FLIGHT) && (r_flight_cnt == FCW'(FLIGHT_TIMEOUT - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^FLIGHT_TIMEOUT;
  assign w_timeout = 1'b0;
`endif

  // The opponent of the active player is the one who loses a life.
  assign w_opp_hp     = r_active ? r_hp0 : r_hp1;
  assign w_opp_hp_nxt = (r_hit_flag && (w_opp_hp != '0)) ? w_opp_hp - 1'b1 : w_opp_hp;

  always_ff @(posedge clk60MHz or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_throw_start <= 1'b0;
      r_active      <= 1'b0;
      r_turn        <= '0;
      r_hp0         <= HP_W'(HP_INIT);
      r_hp1         <= HP_W'(HP_INIT);
      r_game_over   <= 1'b0;
      r_winner      <= 1'b0;
      r_hit_flag    <= 1'b0;
    end else begin
      r_throw_start <= 1'b0;
      case (r_state)
        ST_IDLE:
          if (both_ready)
            r_state <= (r_active == local_player) ? ST_AIM : ST_REMOTE;
        ST_AIM:
          if (w_release) begin
            r_throw_start <= 1'b1;
            r_state       <= ST_FLIGHT;
          end
        ST_REMOTE:
          if (remote_throw)
            r_state <= ST_FLIGHT;
        ST_FLIGHT:
          if (end_throw) begin
            r_hit_flag <= hit;
            r_state    <= ST_SCORE;
          end else if (w_timeout) begin
            r_hit_flag <= 1'b0;
            r_state    <= ST_SCORE;
          end
        ST_SCORE: begin
          if (r_active)
            r_hp0 <= w_opp_hp_nxt;
          else
            r_hp1 <= w_opp_hp_nxt;
          if (w_opp_hp_nxt == '0) begin
            r_game_over <= 1'b1;
            r_winner    <= r_active;
            r_state     <= ST_OVER;
          end else begin
            r_state <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          r_active <= ~r_active;
          r_turn   <= r_turn + 3'd1;
          r_state  <= (~r_active == local_player) ? ST_AIM : ST_REMOTE;
        end
        ST_OVER: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign throw_start   = r_throw_start;
  assign active_player = r_active;
  assign turn          = r_turn;
  assign hp0           = r_hp0;
  assign hp1           = r_hp1;
  assign game_over     = r_game_over;
  assign winner        = r_winner;
  assign state         = r_state;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with a short charge divider and
// flight timeout so full games fit in a few hundred cycles.
module tb_round_sequencer;

  localparam int DIV = 4;
  localparam logic [31:0] S_IDLE = 0, S_AIM = 1, S_REMOTE = 2, S_FLIGHT = 3,
                          S_SCORE = 4, S_SWITCH = 5, S_OVER = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       both_ready = 1'b0;
  logic       local_player = 1'b0;
  logic       left = 1'b0;
  logic       remote_throw = 1'b0;
  logic [4:0] remote_power = '0;
  logic       end_throw = 1'b0;
  logic       hit = 1'b0;
  logic [4:0] power;
  logic       throw_start;
  logic       active_player;
  logic [2:0] turn;
  logic [1:0] hp0;
  logic [1:0] hp1;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  round_sequencer #(
    .CHARGE_DIV     (DIV),
    .FLIGHT_TIMEOUT (100),
    .HP_INIT        (3)
  ) dut (
    .clk60MHz      (clk),
    .rst           (rst),
    .both_ready    (both_ready),
    .local_player  (local_player),
    .left          (left),
    .remote_throw  (remote_throw),
    .remote_power  (remote_power),
    .end_throw     (end_throw),
    .hit           (hit),
    .power         (power),
    .throw_start   (throw_start),
    .active_player (active_player),
    .turn          (turn),
    .hp0           (hp0),
    .hp1           (hp1),
    .game_over     (game_over),
    .winner        (winner),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), S_IDLE);
    chk({tag, "_power"}, 32'(power), 0);
    chk({tag, "_ts"}, 32'(throw_start), 0);
    chk({tag, "_active"}, 32'(active_player), 0);
    chk({tag, "_turn"}, 32'(turn), 0);
    chk({tag, "_hp0"}, 32'(hp0), 3);
    chk({tag, "_hp1"}, 32'(hp1), 3);
    chk({tag, "_over"}, 32'(game_over), 0);
    chk({tag, "_winner"}, 32'(winner), 0);
  endtask

  // Hold the button for `hold` cycles, release, and expect a launch 3 cycles later.
  task automatic press_launch(input int hold, input int exp_pow);
    left = 1'b1;
    tick(hold);
    left = 1'b0;
    tick(2);
    chk("pre_launch_ts", 32'(throw_start), 0);
    tick(1);
    chk("launch_ts", 32'(throw_start), 1);
    chk("launch_state", 32'(state), S_FLIGHT);
    chk("launch_power", 32'(power), 32'(exp_pow));
    tick(1);
    chk("launch_ts_single", 32'(throw_start), 0);
  endtask

  task automatic remote_launch(input logic [4:0] pw);
    remote_throw = 1'b1;
    remote_power = pw;
    tick(1);
    remote_throw = 1'b0;
    chk("remote_state", 32'(state), S_FLIGHT);
    chk("remote_power", 32'(power), 32'(pw));
    chk("remote_ts", 32'(throw_start), 0);
  endtask

  task automatic end_flight(input logic h);
    end_throw = 1'b1;
    hit = h;
    tick(1);
    end_throw = 1'b0;
    hit = 1'b0;
    chk("score_state", 32'(state), S_SCORE);
    tick(1);
  endtask

  initial begin
    rst = 1'b0;
    tick(2);
    chk_reset_vals("reset");

    rst = 1'b1;
    both_ready = 1'b1;
    tick(1);
    chk("idle_to_aim", 32'(state), S_AIM);
    tick(2);

    // Turn 0 (local): 5 charge periods -> power 5.
    press_launch(5 * DIV, 5);
    end_flight(1'b0);
    chk("t0_switch", 32'(state), S_SWITCH);
    chk("t0_power_held", 32'(power), 5);
    chk("t0_hp1", 32'(hp1), 3);
    tick(1);
    chk("t0_next_state", 32'(state), S_REMOTE);
    chk("t0_active", 32'(active_player), 1);
    chk("t0_turn", 32'(turn), 1);
    chk("t0_power_clr", 32'(power), 0);

    // Turn 1 (remote): hit on player 0.
    remote_launch(5'd17);
    end_flight(1'b1);
    chk("t1_hp0", 32'(hp0), 2);
    tick(1);
    chk("t1_next_state", 32'(state), S_AIM);
    chk("t1_turn", 32'(turn), 2);
    chk("t1_active", 32'(active_player), 0);

    // Turn 2 (local): foreign pulses ignored, zero-power release, then saturation.
    remote_throw = 1'b1; remote_power = 5'd9; end_throw = 1'b1; hit = 1'b1;
    tick(1);
    remote_throw = 1'b0; end_throw = 1'b0; hit = 1'b0;
    chk("aim_ignore_state", 32'(state), S_AIM);
    chk("aim_ignore_power", 32'(power), 0);
    left = 1'b1;
    tick(2);
    left = 1'b0;
    tick(3);
    chk("zero_rel_ts", 32'(throw_start), 0);
    chk("zero_rel_state", 32'(state), S_AIM);
    tick(2);
    left = 1'b1;
    tick(40 * DIV);
    chk("sat_power", 32'(power), 31);
    left = 1'b0;
    tick(3);
    chk("sat_ts", 32'(throw_start), 1);
    chk("sat_state", 32'(state), S_FLIGHT);
    tick(1);
    end_flight(1'b1);
    chk("t2_hp1", 32'(hp1), 2);
    tick(1);
    chk("t2_next_state", 32'(state), S_REMOTE);

    // Turn 3 (remote) with the button pressed and held into turn 4.
    left = 1'b1;
    tick(2);
    chk("remote_left_ignored", 32'(power), 0);
    remote_launch(5'd3);
    end_flight(1'b0);
    tick(1);
    chk("t3_next_state", 32'(state), S_AIM);
    chk("t3_turn", 32'(turn), 4);
    tick(3 * DIV);
    chk("held_no_charge", 32'(power), 0);
    left = 1'b0;
    tick(4);
    chk("held_release_state", 32'(state), S_AIM);
    chk("held_release_ts", 32'(throw_start), 0);
    press_launch(DIV, 1);
    end_flight(1'b1);
    chk("t4_hp1", 32'(hp1), 1);
    tick(1);

    // Turn 5 (remote) then turn 6 (local) finishes the game.
    remote_launch(5'd2);
    end_flight(1'b0);
    tick(1);
    chk("t5_next_state", 32'(state), S_AIM);
    tick(2);
    press_launch(DIV, 1);
    end_flight(1'b1);
    chk("over_state", 32'(state), S_OVER);
    chk("over_flag", 32'(game_over), 1);
    chk("over_winner", 32'(winner), 0);
    chk("over_hp1", 32'(hp1), 0);

    left = 1'b1; remote_throw = 1'b1; remote_power = 5'd20; end_throw = 1'b1; hit = 1'b1;
    both_ready = 1'b0;
    tick(2);
    left = 1'b0; remote_throw = 1'b0; end_throw = 1'b0; hit = 1'b0;
    tick(6);
    chk("over_hold_state", 32'(state), S_OVER);
    chk("over_hold_flag", 32'(game_over), 1);
    chk("over_hold_power", 32'(power), 1);
    chk("over_hold_turn", 32'(turn), 6);
    chk("over_hold_hp0", 32'(hp0), 2);
    chk("over_hold_hp1", 32'(hp1), 0);
    chk("over_hold_active", 32'(active_player), 0);
    chk("over_hold_ts", 32'(throw_start), 0);

    // Second game: flight behaviour and mid-flight reset.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    both_ready = 1'b1;
    tick(3);
    press_launch(DIV, 1);
`ifdef ROUND_SEQ_TIMEOUT_EN
    tick(98);
    chk("to_before", 32'(state), S_FLIGHT);
    tick(1);
    chk("to_fire", 32'(state), S_SCORE);
    tick(1);
    chk("to_hp0", 32'(hp0), 3);
    chk("to_hp1", 32'(hp1), 3);
    tick(1);
    chk("to_next_state", 32'(state), S_REMOTE);
    remote_launch(5'd6);
    tick(99);
    end_throw = 1'b1;
    hit = 1'b1;
    tick(1);
    end_throw = 1'b0;
    hit = 1'b0;
    chk("to_tie_score", 32'(state), S_SCORE);
    tick(1);
    chk("to_tie_hp0", 32'(hp0), 2);
    tick(1);
    chk("to_tie_next", 32'(state), S_AIM);
    tick(2);
    press_launch(DIV, 1);
`else
    tick(150);
    chk("no_to_flight", 32'(state), S_FLIGHT);
`endif
    tick(3);
    rst = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    tick(3);
    chk("rst_hold_ts", 32'(throw_start), 0);
    chk("rst_hold_state", 32'(state), S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
